// File: rtl/lab2_proc_fetch_pkg.sv
// Shared constants and the instruction-buffer entry type for the fetch unit.
package lab2_proc_fetch_pkg;

    localparam logic [31:0] c_reset_vector = 32'h0000_0200;
    localparam int          c_max_inflight = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/lab2_proc_fetch_fifo.sv
// Small circular FIFO with synchronous flush; used for in-flight addresses and fetched instructions.
module lab2_proc_fetch_fifo #(
    parameter  int p_width  = 32,
    parameter  int p_depth  = 2,
    localparam int c_ptr_w  = (p_depth > 1) ? $clog2(p_depth) : 1,
    localparam int c_cnt_w  = $clog2(p_depth + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [p_width-1:0] data_i,
    input  logic               pop_i,
    output logic [p_width-1:0] data_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [c_cnt_w-1:0] count_o
);

    logic [p_width-1:0] mem_q [p_depth];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               do_push, do_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(p_depth - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == c_cnt_w'(p_depth));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + c_cnt_w'(do_push) - c_cnt_w'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (push_i && !flush_i) |-> (!full_o || pop_i));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        (pop_i && !flush_i) |-> !empty_o);

endmodule

// File: rtl/lab2_proc_fetch_unit.sv
// Fetch stage: credit-limited imem requests, in-order responses, redirect with drop of stale replies.
module lab2_proc_fetch_unit
    import lab2_proc_fetch_pkg::*;
#(
    parameter logic [31:0] p_reset_vector = c_reset_vector,
    parameter int          p_max_inflight = c_max_inflight
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_msg_addr,
    input  logic        imemresp_val,
    output logic        imemresp_rdy,
    input  logic [31:0] imemresp_msg_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int c_cnt_w = $clog2(p_max_inflight + 1);
    localparam int c_max_i = p_max_inflight;
    localparam logic [c_cnt_w:0] c_credit_max = c_max_i[c_cnt_w:0];

    logic [31:0]        pc_q, pc_d;
    logic [c_cnt_w-1:0] inflight_q, inflight_d;
    logic [c_cnt_w-1:0] drop_q, drop_d;
    logic [c_cnt_w-1:0] buf_count, addr_count;
    logic [c_cnt_w:0]   credit;
    logic               req_fire, resp_fire, resp_keep, inst_fire;
    logic               addr_empty, addr_full, buf_empty, buf_full;
    logic [31:0]        resp_pc;
    fetch_entry_t       buf_wdata, buf_rdata;

    // Buffered instructions hold credit too, so every reply always has a slot waiting.
    assign credit      = {1'b0, inflight_q} + {1'b0, buf_count};
    assign imemreq_val = reset && (credit < c_credit_max) && !redirect_val;
    assign imemreq_msg_addr = pc_q;
    assign imemresp_rdy     = 1'b1;

    assign req_fire  = imemreq_val && imemreq_rdy;
    assign resp_fire = reset && imemresp_val;
    assign resp_keep = resp_fire && (drop_q == '0) && !redirect_val;

    assign inst_val  = !buf_empty;
    assign inst_fire = inst_val && inst_rdy;
    assign inst_data = buf_rdata.inst;
    assign inst_pc   = buf_rdata.pc;

    assign buf_wdata.pc   = resp_pc;
    assign buf_wdata.inst = imemresp_msg_data;

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + c_cnt_w'(req_fire) - c_cnt_w'(resp_fire);
        if (redirect_val) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d   = redirect_target;
            drop_d = inflight_q - c_cnt_w'(resp_fire);
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (resp_fire && (drop_q != '0)) drop_d = drop_q - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= p_reset_vector;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    lab2_proc_fetch_fifo #(
        .p_width (32),
        .p_depth (p_max_inflight)
    ) u_addr_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (resp_fire),
        .data_o  (resp_pc),
        .empty_o (addr_empty),
        .full_o  (addr_full),
        .count_o (addr_count)
    );

    lab2_proc_fetch_fifo #(
        .p_width ($bits(fetch_entry_t)),
        .p_depth (p_max_inflight)
    ) u_inst_buf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_val),
        .push_i  (resp_keep),
        .data_i  (buf_wdata),
        .pop_i   (inst_fire),
        .data_o  (buf_rdata),
        .empty_o (buf_empty),
        .full_o  (buf_full),
        .count_o (buf_count)
    );

    a_inflight_tracks_fifo: assert property (@(posedge clk) disable iff (!reset)
        inflight_q == addr_count);

    a_req_has_slot: assert property (@(posedge clk) disable iff (!reset)
        req_fire |-> !addr_full);

    a_resp_has_addr: assert property (@(posedge clk) disable iff (!reset)
        resp_fire |-> !addr_empty);

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (resp_keep && buf_full) |-> inst_fire);

endmodule
